// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle CPU control FSM and its output decoder.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_LWB   = 4'd4,
    S_MWR   = 4'd5,
    S_REX   = 4'd6,
    S_RWB   = 4'd7,
    S_BEQ   = 4'd8,
    S_J     = 4'd9,
    S_JR    = 4'd10,
    S_IEX   = 4'd11,
    S_IWB   = 4'd12
  } state_e;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Function codes (instruction[5:0]) for R-type
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // ALUOp codes for the downstream ALU control stage
  localparam logic [3:0] ALUOP_ADD      = 4'b0000;
  localparam logic [3:0] ALUOP_SUB      = 4'b0001;
  localparam logic [3:0] ALUOP_FUNCT    = 4'b0010;
  localparam logic [3:0] ALUOP_AND      = 4'b0100;
  localparam logic [3:0] ALUOP_SLT      = 4'b0101;
  localparam logic [3:0] ALUOP_UNSIGNED = 4'b1000;

  // Mux selects
  localparam logic [1:0] REGDST_RT       = 2'd0;
  localparam logic [1:0] REGDST_RD       = 2'd1;
  localparam logic [1:0] REGDST_RA       = 2'd2;
  localparam logic [1:0] MEMTOREG_MDR    = 2'd0;
  localparam logic [1:0] MEMTOREG_ALUOUT = 2'd1;
  localparam logic [1:0] MEMTOREG_PC     = 2'd2;
  localparam logic [1:0] SRCA_PC         = 2'd0;
  localparam logic [1:0] SRCA_REGA       = 2'd1;
  localparam logic [1:0] SRCA_SHAMT      = 2'd2;
  localparam logic [1:0] SRCB_REGB       = 2'd0;
  localparam logic [1:0] SRCB_FOUR       = 2'd1;
  localparam logic [1:0] SRCB_IMM        = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2    = 2'd3;
  localparam logic [1:0] PCSRC_ALU       = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT    = 2'd1;
  localparam logic [1:0] PCSRC_JUMP      = 2'd2;
  localparam logic [1:0] PCSRC_REGA      = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       ext_op;
    logic       lui_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational decode of (state, OpCode, Funct) into datapath controls.
module multicycle_ctrl_decode
  import multicycle_pkg::*;
(
  input  state_e     i_state,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl
);

  // Every control defaults to 0; each state raises only what it needs.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_IF: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.alu_src_a = SRCA_PC;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_ALU;
      end
      S_ID: begin
        o_ctrl.alu_src_a = SRCA_PC;
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.ext_op    = 1'b1;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MADDR: begin
        o_ctrl.alu_src_a = SRCA_REGA;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.ext_op    = 1'b1;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_LWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = REGDST_RT;
        o_ctrl.mem_to_reg = MEMTOREG_MDR;
      end
      S_MWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      S_REX: begin
        o_ctrl.alu_src_b = SRCB_REGB;
        o_ctrl.alu_op    = ALUOP_FUNCT;
        // Shift-immediate forms take the shift amount on the A port
        if (i_funct == FN_SLL || i_funct == FN_SRL || i_funct == FN_SRA) begin
          o_ctrl.alu_src_a = SRCA_SHAMT;
        end else begin
          o_ctrl.alu_src_a = SRCA_REGA;
        end
      end
      S_RWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = REGDST_RD;
        o_ctrl.mem_to_reg = MEMTOREG_ALUOUT;
      end
      S_BEQ: begin
        o_ctrl.alu_src_a     = SRCA_REGA;
        o_ctrl.alu_src_b     = SRCB_REGB;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_J: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
        // PC already holds PC+4 from fetch, so it is the link value
        if (i_opcode == OP_JAL) begin
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.reg_dst    = REGDST_RA;
          o_ctrl.mem_to_reg = MEMTOREG_PC;
        end
      end
      S_JR: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_REGA;
        if (i_funct == FN_JALR) begin
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.reg_dst    = REGDST_RD;
          o_ctrl.mem_to_reg = MEMTOREG_PC;
        end
      end
      S_IEX: begin
        o_ctrl.alu_src_a = SRCA_REGA;
        o_ctrl.alu_src_b = SRCB_IMM;
        case (i_opcode)
          OP_ADDI: begin
            o_ctrl.alu_op = ALUOP_ADD;
            o_ctrl.ext_op = 1'b1;
          end
          OP_ADDIU: begin
            o_ctrl.alu_op = ALUOP_ADD | ALUOP_UNSIGNED;
            o_ctrl.ext_op = 1'b1;
          end
          OP_ANDI: begin
            o_ctrl.alu_op = ALUOP_AND;
          end
          OP_SLTI: begin
            o_ctrl.alu_op = ALUOP_SLT;
            o_ctrl.ext_op = 1'b1;
          end
          OP_SLTIU: begin
            o_ctrl.alu_op = ALUOP_SLT | ALUOP_UNSIGNED;
            o_ctrl.ext_op = 1'b1;
          end
          OP_LUI: begin
            // rs is $0, so A + (imm << 16) yields the upper immediate
            o_ctrl.alu_op = ALUOP_ADD;
            o_ctrl.lui_op = 1'b1;
          end
          default: ;
        endcase
      end
      S_IWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = REGDST_RT;
        o_ctrl.mem_to_reg = MEMTOREG_ALUOUT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle CPU: state register, sequencing, output gating.
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource
);

  state_e r_state;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;

  // State register and sequencing; every instruction ends by returning to fetch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IF;
    end else begin
      case (r_state)
        S_IF: r_state <= S_ID;
        S_ID: begin
          case (OpCode)
            OP_LW, OP_SW: r_state <= S_MADDR;
            OP_RTYPE:     r_state <= (Funct == FN_JR || Funct == FN_JALR) ? S_JR : S_REX;
            OP_BEQ:       r_state <= S_BEQ;
            OP_J, OP_JAL: r_state <= S_J;
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI: r_state <= S_IEX;
            default:      r_state <= S_IF;
          endcase
        end
        S_MADDR: r_state <= (OpCode == OP_LW) ? S_MRD : S_MWR;
        S_MRD:   r_state <= S_LWB;
        S_REX:   r_state <= S_RWB;
        S_IEX:   r_state <= S_IWB;
        default: r_state <= S_IF;
      endcase
    end
  end

  multicycle_ctrl_decode u_decode (
    .i_state  (r_state),
    .i_opcode (OpCode),
    .i_funct  (Funct),
    .o_ctrl   (w_ctrl)
  );

  // Reset is sampled only at the edge, so outputs are also masked while it is low
  // to keep an aborted instruction from writing anything.
  assign w_out = reset ? w_ctrl : '0;

  assign PCWrite     = w_out.pc_write;
  assign PCWriteCond = w_out.pc_write_cond;
  assign IorD        = w_out.iord;
  assign MemRead     = w_out.mem_read;
  assign MemWrite    = w_out.mem_write;
  assign IRWrite     = w_out.ir_write;
  assign RegWrite    = w_out.reg_write;
  assign RegDst      = w_out.reg_dst;
  assign MemtoReg    = w_out.mem_to_reg;
  assign ExtOp       = w_out.ext_op;
  assign LuiOp       = w_out.lui_op;
  assign ALUSrcA     = w_out.alu_src_a;
  assign ALUSrcB     = w_out.alu_src_b;
  assign ALUOp       = w_out.alu_op;
  assign PCSource    = w_out.pc_source;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller; expected controls are hand-coded per cycle.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic       ExtOp, LuiOp;
  logic [3:0] ALUOp;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  multicycle_controller dut (
    .clk         (clk),
    .reset       (reset),
    .OpCode      (OpCode),
    .Funct       (Funct),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .ExtOp       (ExtOp),
    .LuiOp       (LuiOp),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of all outputs:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,RegDst,MemtoReg,
  //  ExtOp,LuiOp,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  logic [22:0] outs;
  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
                 MemtoReg, ExtOp, LuiOp, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  function automatic logic [22:0] mk(input logic pcw, input logic pcwc, input logic iord,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic rw, input logic [1:0] dst, input logic [1:0] mtr,
                                     input logic ext, input logic lui, input logic [1:0] a,
                                     input logic [1:0] b, input logic [3:0] aop,
                                     input logic [1:0] src);
    return {pcw, pcwc, iord, mr, mw, irw, rw, dst, mtr, ext, lui, a, b, aop, src};
  endfunction

  task automatic check_eq(input string tag, input logic [22:0] obs, input logic [22:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h want %06h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check n consecutive cycles of one instruction starting in S_IF, stepping after each.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int n, input logic [22:0] e0, input logic [22:0] e1,
                           input logic [22:0] e2, input logic [22:0] e3, input logic [22:0] e4);
    logic [22:0] ev [5];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3; ev[4] = e4;
    OpCode = op;
    Funct  = fn;
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_c%0d", tag, i + 1), outs, ev[i]);
      step();
    end
  endtask

  logic [22:0] v_if, v_id, v_maddr, v_mrd, v_lwb, v_mwr, v_rex_sh, v_rex, v_rwb;
  logic [22:0] v_beq, v_j, v_jal, v_jr, v_jalr, v_iwb;
  logic [22:0] v_iex_sltiu, v_iex_andi, v_iex_lui, v_iex_addiu;

  initial begin
    v_if        = mk(1,0,0,1,0,1,0, 2'd0,2'd0, 0,0, 2'd0,2'd1, 4'b0000, 2'd0);
    v_id        = mk(0,0,0,0,0,0,0, 2'd0,2'd0, 1,0, 2'd0,2'd3, 4'b0000, 2'd0);
    v_maddr     = mk(0,0,0,0,0,0,0, 2'd0,2'd0, 1,0, 2'd1,2'd2, 4'b0000, 2'd0);
    v_mrd       = mk(0,0,1,1,0,0,0, 2'd0,2'd0, 0,0, 2'd0,2'd0, 4'b0000, 2'd0);
    v_lwb       = mk(0,0,0,0,0,0,1, 2'd0,2'd0, 0,0, 2'd0,2'd0, 4'b0000, 2'd0);
    v_mwr       = mk(0,0,1,0,1,0,0, 2'd0,2'd0, 0,0, 2'd0,2'd0, 4'b0000, 2'd0);
    v_rex_sh    = mk(0,0,0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd2,2'd0, 4'b0010, 2'd0);
    v_rex       = mk(0,0,0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd1,2'd0, 4'b0010, 2'd0);
    v_rwb       = mk(0,0,0,0,0,0,1, 2'd1,2'd1, 0,0, 2'd0,2'd0, 4'b0000, 2'd0);
    v_beq       = mk(0,1,0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd1,2'd0, 4'b0001, 2'd1);
    v_j         = mk(1,0,0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd0,2'd0, 4'b0000, 2'd2);
    v_jal       = mk(1,0,0,0,0,0,1, 2'd2,2'd2, 0,0, 2'd0,2'd0, 4'b0000, 2'd2);
    v_jr        = mk(1,0,0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd0,2'd0, 4'b0000, 2'd3);
    v_jalr      = mk(1,0,0,0,0,0,1, 2'd1,2'd2, 0,0, 2'd0,2'd0, 4'b0000, 2'd3);
    v_iwb       = mk(0,0,0,0,0,0,1, 2'd0,2'd1, 0,0, 2'd0,2'd0, 4'b0000, 2'd0);
    v_iex_sltiu = mk(0,0,0,0,0,0,0, 2'd0,2'd0, 1,0, 2'd1,2'd2, 4'b1101, 2'd0);
    v_iex_andi  = mk(0,0,0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd1,2'd2, 4'b0100, 2'd0);
    v_iex_lui   = mk(0,0,0,0,0,0,0, 2'd0,2'd0, 0,1, 2'd1,2'd2, 4'b0000, 2'd0);
    v_iex_addiu = mk(0,0,0,0,0,0,0, 2'd0,2'd0, 1,0, 2'd1,2'd2, 4'b1000, 2'd0);

    // Reset held for 3 cycles with a lw opcode present: everything must stay 0
    reset  = 1'b0;
    OpCode = 6'h23;
    Funct  = 6'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("reset_c%0d", i + 1), outs, 23'd0);
    end
    reset = 1'b1;
    #1;

    run_instr("lw",    6'h23, 6'h00, 5, v_if, v_id, v_maddr, v_mrd, v_lwb);
    run_instr("sw",    6'h2b, 6'h00, 4, v_if, v_id, v_maddr, v_mwr, '0);
    run_instr("srl",   6'h00, 6'h02, 4, v_if, v_id, v_rex_sh, v_rwb, '0);
    run_instr("addu",  6'h00, 6'h21, 4, v_if, v_id, v_rex, v_rwb, '0);
    run_instr("sltiu", 6'h0b, 6'h00, 4, v_if, v_id, v_iex_sltiu, v_iwb, '0);
    run_instr("andi",  6'h0c, 6'h3f, 4, v_if, v_id, v_iex_andi, v_iwb, '0);
    run_instr("lui",   6'h0f, 6'h00, 4, v_if, v_id, v_iex_lui, v_iwb, '0);
    run_instr("addiu", 6'h09, 6'h00, 4, v_if, v_id, v_iex_addiu, v_iwb, '0);
    run_instr("beq",   6'h04, 6'h00, 3, v_if, v_id, v_beq, '0, '0);
    run_instr("jal",   6'h03, 6'h00, 3, v_if, v_id, v_jal, '0, '0);
    run_instr("j",     6'h02, 6'h09, 3, v_if, v_id, v_j, '0, '0);
    run_instr("jalr",  6'h00, 6'h09, 3, v_if, v_id, v_jalr, '0, '0);
    run_instr("jr",    6'h00, 6'h08, 3, v_if, v_id, v_jr, '0, '0);
    run_instr("unk",   6'h3f, 6'h00, 2, v_if, v_id, '0, '0, '0);

    // sw aborted by reset once it reaches the memory-write cycle
    run_instr("sw_abort", 6'h2b, 6'h00, 3, v_if, v_id, v_maddr, '0, '0);
    reset = 1'b0;
    #1;
    check_eq("sw_abort_mwr", outs, 23'd0);
    step();
    check_eq("sw_abort_held", outs, 23'd0);
    reset = 1'b1;
    #1;
    // Restart from fetch and complete a lw cleanly
    run_instr("lw_after", 6'h23, 6'h00, 5, v_if, v_id, v_maddr, v_mrd, v_lwb);
    check_eq("final_if", outs, v_if);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM of the multi-cycle CPU. Sequences every instruction through fetch, decode, execute, memory and write-back cycles. Drives all datapath enables and mux selects. Produces the 4-bit ALUOp consumed by the ALU control stage, which sits directly downstream.

## Interface
Parameters: none. All encodings are fixed constants in the package.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- OpCode  in  6  instruction[31:26], taken from the instruction register.
- Funct  in  6  instruction[5:0], taken from the instruction register.
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  PC write qualified by ALU Zero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register load.
- RegWrite  out  1  register file write.
- RegDst  out  2  destination register: 0 = rt, 1 = rd, 2 = $31.
- MemtoReg  out  2  write-back data: 0 = MDR, 1 = ALUOut, 2 = PC.
- ExtOp  out  1  immediate extension: 1 = sign, 0 = zero.
- LuiOp  out  1  immediate << 16.
- ALUSrcA  out  2  ALU A input: 0 = PC, 1 = reg A, 2 = shamt.
- ALUSrcB  out  2  ALU B input: 0 = reg B, 1 = const 4, 2 = ext imm, 3 = ext imm << 2.
- ALUOp  out  4  operation code for the ALU control stage.
  - bit 3: 1 = unsigned.
  - [2:0]: 000 add, 001 sub, 100 and, 101 slt, 010 use Funct.
- PCSource  out  2  next-PC select: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = reg A.

## Operation
- Moore FSM with a 4-bit state register. Outputs are decoded from the state, plus OpCode/Funct where noted. Any output not listed for a state is 0.
- S_IF:
  - Fetch: MemRead=1, IorD=0, IRWrite=1.
  - PC+4: ALUSrcA=0, ALUSrcB=1, ALUOp=0000, PCWrite=1, PCSource=0.
  - Next state: S_ID.
- S_ID:
  - Branch target into ALUOut: ALUSrcA=0, ALUSrcB=3, ExtOp=1, ALUOp=0000.
  - Dispatch on OpCode:
    - lw/sw (0x23/0x2b) → S_MADDR.
    - R-type (0x00): Funct 0x08/0x09 → S_JR; otherwise → S_REX.
    - beq (0x04) → S_BEQ.
    - j/jal (0x02/0x03) → S_J.
    - addi/addiu/andi/slti/sltiu/lui (0x08/0x09/0x0c/0x0a/0x0b/0x0f) → S_IEX.
    - Any other opcode → S_IF (executes as a nop).
- S_MADDR: ALUSrcA=1, ALUSrcB=2, ExtOp=1, ALUOp=0000. lw → S_MRD; sw → S_MWR.
- S_MRD: MemRead=1, IorD=1 → S_LWB.
- S_LWB: RegWrite=1, RegDst=0, MemtoReg=0 → S_IF.
- S_MWR: MemWrite=1, IorD=1 → S_IF.
- S_REX: ALUSrcB=0, ALUOp=0010. ALUSrcA=2 for Funct 0x00/0x02/0x03, else 1. → S_RWB.
- S_RWB: RegWrite=1, RegDst=1, MemtoReg=1 → S_IF.
- S_BEQ: ALUSrcA=1, ALUSrcB=0, ALUOp=0001, PCWriteCond=1, PCSource=1 → S_IF.
- S_J: PCWrite=1, PCSource=2. For jal only: RegWrite=1, RegDst=2, MemtoReg=2, linking the already-incremented PC. → S_IF.
- S_JR: PCWrite=1, PCSource=3. For jalr only: RegWrite=1, RegDst=1, MemtoReg=2. → S_IF.
- S_IEX: ALUSrcA=1, ALUSrcB=2 → S_IWB. Per opcode:
  - addi: ALUOp 0000, ExtOp=1.
  - addiu: ALUOp 1000, ExtOp=1.
  - andi: ALUOp 0100, ExtOp=0.
  - slti: ALUOp 0101, ExtOp=1.
  - sltiu: ALUOp 1101, ExtOp=1.
  - lui: ALUOp 0000, LuiOp=1 (rs = $0).
- S_IWB: RegWrite=1, RegDst=0, MemtoReg=1 → S_IF.
- Unused state encodings → S_IF on the next edge.

## Timing
- Reset:
  - reset=0 sampled at a rising edge → state = S_IF.
  - While reset=0, all outputs are forced to 0, including PCWrite, IRWrite, MemWrite and RegWrite.
  - Reset asserted mid-instruction aborts it with no further writes.
- Latency in cycles, counted from S_IF entry:
  - beq, j, jal, jr, jalr, unknown opcode: 3 (unknown: 2).
  - R-type, I-type, sw: 4.
  - lw: 5.
- Exactly one state per clock. There are no stalls and no handshakes; memory is single-cycle.
- S_IF is re-entered on the edge that ends the final state of each instruction. No idle cycles occur between instructions.
- OpCode/Funct are valid from S_ID onward. They are ignored in S_IF, since IR updates at the end of that cycle.

## Structure
- Package multicycle_pkg holds:
  - state encodings.
  - OpCode/Funct constants.
  - ALUOp codes (ALUOP_ADD=0000, SUB=0001, FUNCT=0010, AND=0100, SLT=0101, UNSIGNED bit).
  - mux-select constants for RegDst, MemtoReg, ALUSrcA/B and PCSource.
- One sub-module, multicycle_ctrl_decode: combinational map (state, OpCode, Funct) → outputs. The top module holds the state register and next-state logic.

## Test plan
- Reset held low 3 cycles with OpCode=0x23 → all outputs 0. Release → PCWrite=1, IRWrite=1, ALUOp=0000 in the first cycle.
- lw (0x23) → state trace S_IF, S_ID, S_MADDR, S_MRD, S_LWB. MemRead=1 with IorD=1 in cycle 4; RegWrite=1, MemtoReg=0 in cycle 5; back in S_IF in cycle 6.
- R-type srl (Funct 0x02) → S_REX with ALUSrcA=2, ALUOp=0010. addu (0x21) → ALUSrcA=1. Both write back with RegDst=1.
- sltiu (0x0b) → ALUOp=1101, ExtOp=1. andi (0x0c) → ALUOp=0100, ExtOp=0.
- jal (0x03) → cycle 3 has PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2. jalr → PCSource=3, RegDst=1.
- OpCode 0x3f → S_IF, S_ID, S_IF with no RegWrite/MemWrite. Reset pulsed during S_MWR of sw → MemWrite never asserted.
